ram_fifo_ctrl: RTL and testbench



---
 rtl/ram_fifo_ctrl.sv | 126 ++++++++++++
 tb/tb_ram_fifo_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: synchronous FIFO controller in front of an 8x16 dual-port RAM.
// Keeps the write/read pointers and the occupancy count, and drives the RAM
// write port, read port and clear. It also returns popped words to the
// consumer with a one-cycle-latency valid strobe. The RAM read data is
// registered inside the RAM, so the word read at edge N is presented here in
// cycle N+1, which lines up with rd_valid_q.
module ram_fifo_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int DATA_DEPTH = 8,
  parameter int DATA_ADDR  = 3
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_ADDR:0]    count,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  ram_clear,
  output logic                  ram_we,
  output logic [DATA_ADDR-1:0]  ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_re,
  output logic [DATA_ADDR-1:0]  ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  // DATA_DEPTH is a power of two, so the pointers wrap naturally on overflow
  // of their DATA_ADDR bits.
  localparam logic [DATA_ADDR:0]   DEPTH_C   = (DATA_ADDR+1)'(DATA_DEPTH);
  localparam logic [DATA_ADDR:0]   CNT_ZERO  = {(DATA_ADDR+1){1'b0}};
  localparam logic [DATA_ADDR:0]   CNT_ONE   = {{DATA_ADDR{1'b0}}, 1'b1};
  localparam logic [DATA_ADDR-1:0] PTR_ZERO  = {DATA_ADDR{1'b0}};
  localparam logic [DATA_ADDR-1:0] PTR_ONE   = {{(DATA_ADDR-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  logic [DATA_ADDR-1:0] wr_ptr_q, wr_ptr_d;
  logic [DATA_ADDR-1:0] rd_ptr_q, rd_ptr_d;
  logic [DATA_ADDR:0]   count_q, count_d;
  logic                 rd_valid_q, rd_valid_d;

  logic full_s;
  logic empty_s;
  logic push_ok_s;
  logic pop_ok_s;

  // Occupancy flags and request acceptance. A push at full is refused even
  // with a simultaneous pop, so the RAM never sees a read and a write to the
  // same address in one cycle; symmetrically a pop at empty is refused.
  always_comb begin
    full_s    = (count_q == DEPTH_C);
    empty_s   = (count_q == CNT_ZERO);
    push_ok_s = wr_en & ~full_s  & ~clear;
    pop_ok_s  = rd_en & ~empty_s & ~clear;
  end

  // Next-state for pointers, count and the read-valid strobe.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_valid_d = pop_ok_s;

    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // State registers; clear discards stored words and any in-flight pop.
  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr_q   <= PTR_ZERO;
      rd_ptr_q   <= PTR_ZERO;
      count_q    <= CNT_ZERO;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // RAM port drive, status outputs and consumer-side read data.
  always_comb begin
    ram_clear   = clear;
    ram_we      = push_ok_s;
    ram_wr_addr = wr_ptr_q;
    ram_din     = wr_data;
    ram_re      = pop_ok_s;
    ram_rd_addr = rd_ptr_q;

    full      = full_s;
    empty     = empty_s;
    count     = count_q;
    overflow  = wr_en & full_s  & ~clear;
    underflow = rd_en & empty_s & ~clear;

    rd_valid = rd_valid_q;
    if (rd_valid_q) begin
      rd_data = ram_dout;
    end else begin
      rd_data = DATA_ZERO;
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: includes a behavioural 8x16 RAM, a queue-based
// FIFO reference model, a table of hand-computed vectors, directed corner
// sequences and a randomized phase.
module tb_ram_fifo_ctrl;

  logic        clk;
  logic        clear;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        rd_en;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        full;
  logic        empty;
  logic [3:0]  count;
  logic        overflow;
  logic        underflow;
  logic        ram_clear;
  logic        ram_we;
  logic [2:0]  ram_wr_addr;
  logic [15:0] ram_din;
  logic        ram_re;
  logic [2:0]  ram_rd_addr;
  logic [15:0] ram_dout;

  ram_fifo_ctrl #(.DATA_WIDTH(16), .DATA_DEPTH(8), .DATA_ADDR(3)) dut (
    .clk(clk), .clear(clear), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .count(count), .overflow(overflow), .underflow(underflow),
    .ram_clear(ram_clear), .ram_we(ram_we), .ram_wr_addr(ram_wr_addr),
    .ram_din(ram_din), .ram_re(ram_re), .ram_rd_addr(ram_rd_addr),
    .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural dual-port RAM with synchronous clear and registered read.
  logic [15:0] mem [8];
  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 8; i++) mem[i] <= 16'h0000;
      ram_dout <= 16'h0000;
    end else begin
      if (ram_we) mem[ram_wr_addr] <= ram_din;
      if (ram_re) ram_dout <= mem[ram_rd_addr];
    end
  end

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: a queue of stored words plus accepted-operation tallies.
  logic [15:0] mq [$];
  int          n_push = 0;
  int          n_pop  = 0;
  logic        m_vld  = 1'b0;
  logic [15:0] m_dat  = 16'h0000;
  logic        m_push;
  logic        m_pop;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Apply inputs, move to the falling edge and compare against the model.
  task automatic drive(input logic c, input logic w, input logic [15:0] d, input logic r);
    int   cnt;
    logic mfull, mempty;
    clear = c; wr_en = w; wr_data = d; rd_en = r;
    @(negedge clk);
    cnt    = mq.size();
    mfull  = (cnt == 8);
    mempty = (cnt == 0);
    m_push = w & ~mfull & ~c;
    m_pop  = r & ~mempty & ~c;
    chk("count",     32'(count),       32'(cnt));
    chk("full",      32'(full),        32'(mfull));
    chk("empty",     32'(empty),       32'(mempty));
    chk("overflow",  32'(overflow),    32'(w & mfull & ~c));
    chk("underflow", 32'(underflow),   32'(r & mempty & ~c));
    chk("ram_we",    32'(ram_we),      32'(m_push));
    chk("ram_re",    32'(ram_re),      32'(m_pop));
    chk("ram_clear", 32'(ram_clear),   32'(c));
    chk("rd_valid",  32'(rd_valid),    32'(m_vld));
    chk("rd_data",   32'(rd_data),     32'(m_vld ? m_dat : 16'h0000));
    chk("wr_addr",   32'(ram_wr_addr), 32'(n_push % 8));
    chk("rd_addr",   32'(ram_rd_addr), 32'(n_pop % 8));
    if (m_push) chk("ram_din", 32'(ram_din), 32'(d));
  endtask

  // Cross the rising edge and update the model with what was accepted.
  task automatic advance();
    @(posedge clk);
    if (clear) begin
      mq.delete();
      n_push = 0; n_pop = 0; m_vld = 1'b0; m_dat = 16'h0000;
    end else begin
      m_vld = m_pop;
      if (m_pop) begin
        m_dat = mq.pop_front();
        n_pop++;
      end
      if (m_push) begin
        mq.push_back(wr_data);
        n_push++;
      end
    end
    #1;
  endtask

  task automatic step(input logic c, input logic w, input logic [15:0] d, input logic r);
    drive(c, w, d, r);
    advance();
  endtask

  typedef struct packed {
    logic        clr;
    logic        we;
    logic [15:0] wd;
    logic        re;
    logic [3:0]  cnt;
    logic        ovf;
    logic        unf;
    logic        vld;
    logic [15:0] dat;
  } vec_t;

  vec_t tbl [27];
  logic [15:0] wseq [12];

  initial begin
    // clr we wd re | cnt ovf unf vld dat  (outputs seen before the edge)
    tbl[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[1]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[2]  = '{1'b0, 1'b1, 16'h1111, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[3]  = '{1'b0, 1'b1, 16'hFFFF, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[4]  = '{1'b0, 1'b1, 16'h1010, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[5]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[6]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 16'h1111};
    tbl[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 16'hFFFF};
    tbl[8]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 16'h1010};
    tbl[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 16'h0000};
    tbl[10] = '{1'b0, 1'b0, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000};
    for (int i = 0; i < 8; i++)
      tbl[11+i] = '{1'b0, 1'b1, 16'(i+1), 1'b0, 4'(i), 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[19] = '{1'b0, 1'b1, 16'h0009, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0, 16'h0000};
    tbl[20] = '{1'b0, 1'b1, 16'h000A, 1'b1, 4'd8, 1'b1, 1'b0, 1'b0, 16'h0000};
    tbl[21] = '{1'b0, 1'b0, 16'h0000, 1'b0, 4'd7, 1'b0, 1'b0, 1'b1, 16'h0001};
    tbl[22] = '{1'b1, 1'b1, 16'h7777, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[23] = '{1'b0, 1'b0, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[24] = '{1'b0, 1'b1, 16'h5A5A, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 16'h0000};
    tbl[25] = '{1'b0, 1'b0, 16'h0000, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[26] = '{1'b0, 1'b0, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 16'h5A5A};

    clear = 1'b1; wr_en = 1'b0; wr_data = 16'h0000; rd_en = 1'b0;
    @(posedge clk); #1;

    // Table-driven vectors: hand-computed expectations plus model checks.
    for (int i = 0; i < 27; i++) begin
      drive(tbl[i].clr, tbl[i].we, tbl[i].wd, tbl[i].re);
      chk($sformatf("tbl%0d_count", i), 32'(count),     32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_ovf", i),   32'(overflow),  32'(tbl[i].ovf));
      chk($sformatf("tbl%0d_unf", i),   32'(underflow), 32'(tbl[i].unf));
      chk($sformatf("tbl%0d_vld", i),   32'(rd_valid),  32'(tbl[i].vld));
      chk($sformatf("tbl%0d_dat", i),   32'(rd_data),   32'(tbl[i].dat));
      advance();
    end

    // Wrap-around: push 6, pop 6, push 6, pop 6; pointers cross 7 -> 0.
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 12; i++) wseq[i] = 16'hC000 + 16'(i * 16'h0101);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 6; i++) begin
        drive(1'b0, 1'b1, wseq[k*6+i], 1'b0);
        chk("wrap_wr_addr", 32'(ram_wr_addr), 32'((k*6+i) % 8));
        advance();
      end
      for (int i = 0; i < 6; i++) begin
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        if (i > 0) chk("wrap_data", 32'(rd_data), 32'(wseq[k*6+i-1]));
        advance();
      end
      drive(1'b0, 1'b0, 16'h0000, 1'b0);
      chk("wrap_last", 32'(rd_data), 32'(wseq[k*6+5]));
      advance();
    end

    // Simultaneous push and pop at count=3: count holds, addresses differ.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h3300 + 16'(i), 1'b0);
    drive(1'b0, 1'b1, 16'h33AA, 1'b1);
    chk("sim_both_en", 32'({ram_we, ram_re}), 32'(2'b11));
    chk("sim_addr_diff", 32'(ram_wr_addr != ram_rd_addr), 32'(1'b1));
    advance();
    drive(1'b0, 1'b0, 16'h0000, 1'b0);
    chk("sim_count3", 32'(count), 32'(4'd3));
    advance();

    // Clear mid-stream right after an accepted pop at count=5.
    step(1'b0, 1'b1, 16'h4444, 1'b0);
    step(1'b0, 1'b1, 16'h5555, 1'b0);
    drive(1'b0, 1'b0, 16'h0000, 1'b1);
    chk("mid_count5", 32'(count), 32'(4'd5));
    advance();
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    drive(1'b0, 1'b1, 16'hABCD, 1'b0);
    chk("mid_vld0", 32'(rd_valid), 32'(1'b0));
    chk("mid_empty", 32'(empty), 32'(1'b1));
    advance();
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    drive(1'b0, 1'b0, 16'h0000, 1'b0);
    chk("mid_abcd", 32'(rd_data), 32'(16'hABCD));
    advance();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
           16'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
